// File: rtl/axi_read_pkg.sv
// Shared AXI read-path definitions: burst/response codes, slave FSM states and the
// packed AR entry layout used by both the slave request queue and master-side packing.
package axi_read_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_BURST = 2'd2
    } rd_state_t;

    // Fixed-width AR control fields; an entry is {id, addr, ar_ctl_t} from MSB to LSB.
    typedef struct packed {
        logic [3:0] len;
        logic [1:0] size;
        logic [1:0] burst;
        logic [1:0] lock;
        logic [3:0] cache;
        logic [2:0] prot;
    } ar_ctl_t;

    localparam int unsigned AR_CTL_W    = $bits(ar_ctl_t);
    localparam int unsigned AR_CTL_LSB  = 0;
    localparam int unsigned AR_ADDR_LSB = AR_CTL_LSB + AR_CTL_W;

    function automatic int unsigned ar_id_lsb(input int unsigned addr_w);
        return AR_ADDR_LSB + addr_w;
    endfunction

    function automatic int unsigned ar_entry_w(input int unsigned addr_w, input int unsigned id_w);
        return ar_id_lsb(addr_w) + id_w;
    endfunction

    // Beats wider than the 32-bit word are not supported; size 3 collapses to 4 bytes.
    function automatic logic [1:0] eff_size(input logic [1:0] size);
        return (size == 2'd3) ? 2'd2 : size;
    endfunction

endpackage

// File: rtl/axi_read_slave_if.sv
// AXI read address/data channel bundle between a read master and the read slave.
interface axi_read_slave_if #(
    parameter int unsigned BusWidth = 32,
    parameter int unsigned tagbits  = 1
);
    logic [tagbits-1:0]  ARID;
    logic [BusWidth-1:0] ARADDR;
    logic [3:0]          ARLEN;
    logic [1:0]          ARSIZE;
    logic [1:0]          ARBURST;
    logic [1:0]          ARLOCK;
    logic [3:0]          ARCACHE;
    logic [2:0]          ARPROT;
    logic                ARVALID;
    logic                ARREADY;

    logic [tagbits-1:0]  RID;
    logic [BusWidth-1:0] RDATA;
    logic [1:0]          RRESP;
    logic                RLAST;
    logic                RVALID;
    logic                RREADY;

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARVALID, RREADY,
        input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARVALID, RREADY,
        output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );
endinterface

// File: rtl/axi_ar_queue.sv
// Synchronous FIFO for packed AR entries with registered full/empty flags and occupancy.
module axi_ar_queue #(
    parameter int unsigned Width = 49,
    parameter int unsigned Depth = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [Width-1:0]         din,
    input  logic                     pop,
    output logic [Width-1:0]         head_c,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(Depth):0]   count
);
    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic             push_ok;
    logic             pop_ok;
    logic [CntW-1:0]  count_nxt;

    assign push_ok   = push && !full;
    assign pop_ok    = pop && !empty;
    assign count_nxt = count + CntW'(push_ok) - CntW'(pop_ok);
    assign head_c    = mem[rd_ptr];

    // Entry storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PtrW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PtrW'(1);
            count <= count_nxt;
            full  <= (count_nxt == CntW'(Depth));
            empty <= (count_nxt == '0);
        end
    end
endmodule

// File: rtl/axi_read_slave.sv
// AXI read slave: queues AR requests and serves them in order as R bursts from a preloadable memory.
// Optional RSLV_ERR_RESP_EN: out-of-range beats return SLVERR with zero data instead of aliasing.
module axi_read_slave
    import axi_read_pkg::*;
#(
    parameter int unsigned BusWidth   = 32,
    parameter int unsigned tagbits    = 1,
    parameter int unsigned MemDepth   = 64,
    parameter int unsigned QueueDepth = 2
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    axi_read_slave_if.slave             bus,
    input  logic                        mem_we,
    input  logic [$clog2(MemDepth)-1:0] mem_waddr,
    input  logic [BusWidth-1:0]         mem_wdata
);
    localparam int unsigned IdxW   = $clog2(MemDepth);
    localparam int unsigned EntryW = ar_entry_w(BusWidth, tagbits);
    localparam int unsigned IdLsb  = ar_id_lsb(BusWidth);

    logic [BusWidth-1:0] mem [MemDepth];

    ar_ctl_t                 ar_ctl_c;
    logic [EntryW-1:0]       entry_c;
    logic [EntryW-1:0]       head_c;
    ar_ctl_t                 head_ctl;
    logic [BusWidth-1:0]     head_addr;
    logic [tagbits-1:0]      head_id;
    logic                    q_full;
    logic                    q_empty;
    logic [$clog2(QueueDepth):0] q_count;
    logic                    q_push_c;
    logic                    q_pop_c;

    rd_state_t               state;
    logic [BusWidth-1:0]     addr_q;
    logic [3:0]              beats_q;
    logic [3:0]              cur_len;
    logic [1:0]              cur_size;
    logic [1:0]              cur_burst;
    logic                    rvalid_q;
    logic                    rlast_q;
    logic [tagbits-1:0]      rid_q;
    logic [BusWidth-1:0]     rdata_q;
    logic [1:0]              rresp_q;

    logic [BusWidth-1:0]     step_c;
    logic [BusWidth-1:0]     span_c;
    logic                    wrap_ok_c;
    logic [BusWidth-1:0]     nxt_addr_c;
    logic [BusWidth-1:0]     beat_addr_c;
    logic [IdxW-1:0]         beat_idx_c;
    logic [BusWidth-1:0]     beat_data_c;
    logic [1:0]              beat_resp_c;
    logic                    unused_bits;

    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign ar_ctl_c = '{len: bus.ARLEN, size: bus.ARSIZE, burst: bus.ARBURST,
                        lock: bus.ARLOCK, cache: bus.ARCACHE, prot: bus.ARPROT};
    assign entry_c  = {bus.ARID, bus.ARADDR, ar_ctl_c};
    assign q_push_c = bus.ARVALID && !q_full;
    assign q_pop_c  = (state == ST_LOAD);

    axi_ar_queue #(
        .Width (EntryW),
        .Depth (QueueDepth)
    ) u_ar_queue (
        .clk    (ACLK),
        .rst    (ARESET),
        .push   (q_push_c),
        .din    (entry_c),
        .pop    (q_pop_c),
        .head_c (head_c),
        .full   (q_full),
        .empty  (q_empty),
        .count  (q_count)
    );

    assign head_ctl  = ar_ctl_t'(head_c[AR_CTL_LSB +: AR_CTL_W]);
    assign head_addr = head_c[AR_ADDR_LSB +: BusWidth];
    assign head_id   = head_c[IdLsb +: tagbits];

    // Address of the beat after the current one, per burst type.
    always_comb begin
        step_c     = BusWidth'(1) << cur_size;
        span_c     = BusWidth'({1'b0, cur_len} + 5'd1) << cur_size;
        wrap_ok_c  = (cur_burst == BURST_WRAP) &&
                     ((cur_len == 4'd1) || (cur_len == 4'd3) ||
                      (cur_len == 4'd7) || (cur_len == 4'd15));
        nxt_addr_c = addr_q + step_c;
        if (cur_burst == BURST_FIXED) begin
            nxt_addr_c = addr_q;
        end else if (wrap_ok_c) begin
            nxt_addr_c = (addr_q & ~(span_c - BusWidth'(1))) |
                         ((addr_q + step_c) & (span_c - BusWidth'(1)));
        end
    end

    // Data/response for the beat about to be presented (first beat in LOAD, next beat otherwise).
    always_comb begin
        beat_addr_c = (state == ST_LOAD) ? head_addr : nxt_addr_c;
        beat_idx_c  = beat_addr_c[IdxW+1:2];
        beat_data_c = mem[beat_idx_c];
        beat_resp_c = RESP_OKAY;
`ifdef RSLV_ERR_RESP_EN
        if ((beat_addr_c >> (IdxW + 2)) != '0) begin
            beat_data_c = '0;
            beat_resp_c = RESP_SLVERR;
        end
`endif
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state     <= ST_IDLE;
            addr_q    <= '0;
            beats_q   <= '0;
            cur_len   <= '0;
            cur_size  <= '0;
            cur_burst <= BURST_FIXED;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (!q_empty) state <= ST_LOAD;
                end
                ST_LOAD: begin
                    addr_q    <= head_addr;
                    beats_q   <= head_ctl.len;
                    cur_len   <= head_ctl.len;
                    cur_size  <= eff_size(head_ctl.size);
                    cur_burst <= head_ctl.burst;
                    rid_q     <= head_id;
                    rvalid_q  <= 1'b1;
                    rlast_q   <= (head_ctl.len == 4'd0);
                    rdata_q   <= beat_data_c;
                    rresp_q   <= beat_resp_c;
                    state     <= ST_BURST;
                end
                ST_BURST: begin
                    if (bus.RREADY) begin
                        if (beats_q == 4'd0) begin
                            rvalid_q <= 1'b0;
                            rlast_q  <= 1'b0;
                            state    <= q_empty ? ST_IDLE : ST_LOAD;
                        end else begin
                            addr_q  <= nxt_addr_c;
                            beats_q <= beats_q - 4'd1;
                            rlast_q <= (beats_q == 4'd1);
                            rdata_q <= beat_data_c;
                            rresp_q <= beat_resp_c;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ARREADY = !q_full;
    assign bus.RVALID  = rvalid_q;
    assign bus.RLAST   = rlast_q;
    assign bus.RID     = rid_q;
    assign bus.RDATA   = rdata_q;
    assign bus.RRESP   = rresp_q;

    // Queued-but-ignored AR attributes and upper address bits are intentionally unused.
    assign unused_bits = ^{head_ctl.lock, head_ctl.cache, head_ctl.prot, q_count, beat_addr_c};
endmodule
